// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited
// memory requests, in-order prefetch queue, and redirect flush with
// discard of wrong-path responses still in flight.
module fetch_prefetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] target_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus_4,
   output logic [31:0] if_instruction
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [31:0]      pc_q;
   logic [31:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];
   logic [31:0]      tag_mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] tag_rd;
   logic [PTR_W-1:0] tag_wr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop;

   logic             credit_ok;
   logic             req_fire;
   logic             rsp_keep;
   logic             pop;
   logic [CNT_W-1:0] outstanding_next;

   // Handshake qualifiers and credit accounting; buffered plus in-flight never exceeds DEPTH
   always_comb begin
      credit_ok        = (count + outstanding) < DEPTH_C;
      imem_req_valid   = !rst && !redirect && credit_ok;
      req_fire         = imem_req_valid && imem_req_ready;
      rsp_keep         = imem_rsp_valid && !redirect && (drop == '0);
      pop              = if_valid && if_ready && !redirect;
      outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
   end

   assign imem_req_addr  = pc_q;
   assign if_valid       = (count != '0);
   assign if_pc          = q_pc[rd_ptr];
   assign if_instruction = q_instr[rd_ptr];
   assign if_pc_plus_4   = if_pc + 32'd4;

   // PC, pointers and counters; redirect empties the queue and marks in-flight responses for discard
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (imem_rsp_valid) tag_rd <= tag_rd + PTR_W'(1);
         if (req_fire)       tag_wr <= tag_wr + PTR_W'(1);
         if (redirect) begin
            pc_q   <= target_pc;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            drop   <= outstanding_next;
         end else begin
            if (req_fire) pc_q <= pc_q + 32'd4;
            if (imem_rsp_valid && (drop != '0)) drop <= drop - CNT_W'(1);
            if (rsp_keep) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(rsp_keep) - CNT_W'(pop);
         end
      end
   end

   // Tag FIFO of request PCs and the {pc, instruction} queue storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tag_mem[i] <= '0;
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else begin
         if (req_fire) tag_mem[tag_wr] <= pc_q;
         if (rsp_keep) begin
            q_pc[wr_ptr]    <= tag_mem[tag_rd];
            q_instr[wr_ptr] <= imem_rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order fixed-latency memory model.
module tb_fetch_prefetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] target_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus_4;
   logic [31:0] if_instruction;

   int vectors     = 0;
   int miscompares = 0;
   int mem_lat     = 1;
   int cyc         = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] req_log[$];

   fetch_prefetch_queue #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect       (redirect),
      .target_pc      (target_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_pc_plus_4   (if_pc_plus_4),
      .if_instruction (if_instruction)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   // Memory model: samples handshakes mid-cycle, answers mem_lat cycles after acceptance, in order
   initial begin
      logic        s_fire;
      logic        s_rsp;
      logic        s_rst;
      logic [31:0] s_addr;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         s_fire = imem_req_valid && imem_req_ready;
         s_addr = imem_req_addr;
         s_rsp  = imem_rsp_valid;
         s_rst  = rst;
         @(posedge clk);
         cyc++;
         if (s_rst) begin
            pend.delete();
         end else begin
            if (s_rsp && pend.size() > 0) void'(pend.pop_front());
            if (s_fire) begin
               pend.push_back('{s_addr, cyc + mem_lat - 1});
               req_log.push_back(s_addr);
            end
         end
         #1;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   task automatic do_reset(input logic rdy, input int lat);
      rst      = 1'b1;
      redirect = 1'b0;
      if_ready = rdy;
      mem_lat  = lat;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      req_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect = 1'b0; target_pc = '0; if_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
      vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
      vectors++; if (if_instruction !== 32'h0) begin miscompares++; $display("FAIL reset_if_instr: got %h want 00000000", if_instruction); end
      vectors++; if (if_pc_plus_4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus_4: got %h want 00000004", if_pc_plus_4); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_valid: got %b want 1", imem_req_valid); end
      vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL post_reset_req_addr: got %h want 00000100", imem_req_addr); end
   endtask

   task automatic test_free_run();
      logic [31:0] exp;
      do_reset(1'b1, 1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         exp = 32'h100 + 32'(4 * (c - 1));
         vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp) begin miscompares++; $display("FAIL free_req c%0d: got v=%b a=%h want v=1 a=%h", c, imem_req_valid, imem_req_addr, exp); end
         if (c < 3) begin
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL free_early_valid c%0d: got %b want 0", c, if_valid); end
         end else begin
            exp = 32'h100 + 32'(4 * (c - 3));
            vectors++; if (if_valid !== 1'b1 || if_pc !== exp) begin miscompares++; $display("FAIL free_head c%0d: got v=%b pc=%h want v=1 pc=%h", c, if_valid, if_pc, exp); end
            vectors++; if (if_instruction !== instr_of(exp)) begin miscompares++; $display("FAIL free_instr c%0d: got %h want %h", c, if_instruction, instr_of(exp)); end
            vectors++; if (if_pc_plus_4 !== exp + 32'd4) begin miscompares++; $display("FAIL free_pc4 c%0d: got %h want %h", c, if_pc_plus_4, exp + 32'd4); end
         end
      end
   endtask

   task automatic test_stall();
      int          n;
      logic [31:0] exp;
      do_reset(1'b0, 1);
      repeat (10) @(negedge clk);
      vectors++; if (req_log.size() != 4) begin miscompares++; $display("FAIL stall_req_count: got %0d want 4", req_log.size()); end
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin miscompares++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc); end
      @(posedge clk); #1;
      if_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (if_valid === 1'b1) begin
            exp = 32'h100 + 32'(4 * n);
            vectors++; if (if_pc !== exp || if_instruction !== instr_of(exp)) begin miscompares++; $display("FAIL stall_drain pop%0d: got pc=%h ins=%h want pc=%h ins=%h", n, if_pc, if_instruction, exp, instr_of(exp)); end
            n++;
         end
      end
      vectors++; if (n != 12) begin miscompares++; $display("FAIL stall_drain_count: got %0d want 12", n); end
   endtask

   task automatic test_redirect_latency();
      do_reset(1'b1, 3);
      for (int c = 1; c <= 10; c++) begin
         redirect  = (c == 4);
         target_pc = 32'h400;
         @(negedge clk);
         if (c == 4) begin
            vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_req_blocked: got %b want 0", imem_req_valid); end
         end
         if (c == 5) begin
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin miscompares++; $display("FAIL redir_first_req: got v=%b a=%h want v=1 a=00000400", imem_req_valid, imem_req_addr); end
         end
         if (c <= 8) begin
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_stale_valid c%0d: got %b pc=%h want 0", c, if_valid, if_pc); end
         end
         if (c == 9) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instruction !== instr_of(32'h400)) begin miscompares++; $display("FAIL redir_target_head: got v=%b pc=%h ins=%h want v=1 pc=00000400", if_valid, if_pc, if_instruction); end
         end
         if (c == 10) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h404) begin miscompares++; $display("FAIL redir_second_head: got v=%b pc=%h want v=1 pc=00000404", if_valid, if_pc); end
         end
         @(posedge clk); #1;
      end
      redirect = 1'b0;
   endtask

   task automatic test_double_redirect();
      logic [31:0] exp;
      do_reset(1'b1, 3);
      for (int c = 1; c <= 12; c++) begin
         redirect  = (c == 3) || (c == 5);
         target_pc = (c == 3) ? 32'h200 : 32'h300;
         @(negedge clk);
         if (if_valid === 1'b1 && if_pc[31:8] == 24'h000002) begin
            vectors++; miscompares++; $display("FAIL dbl_wrong_path c%0d: got pc=%h want no 0x2xx entry", c, if_pc);
         end
         if (c == 4) begin
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL dbl_req_200: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
         end
         if (c == 6) begin
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin miscompares++; $display("FAIL dbl_req_300: got v=%b a=%h want v=1 a=00000300", imem_req_valid, imem_req_addr); end
         end
         if (c >= 3 && c <= 9) begin
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL dbl_empty c%0d: got %b pc=%h want 0", c, if_valid, if_pc); end
         end
         if (c >= 10) begin
            exp = 32'h300 + 32'(4 * (c - 10));
            vectors++; if (if_valid !== 1'b1 || if_pc !== exp || if_instruction !== instr_of(exp)) begin miscompares++; $display("FAIL dbl_head c%0d: got v=%b pc=%h ins=%h want v=1 pc=%h", c, if_valid, if_pc, if_instruction, exp); end
         end
         @(posedge clk); #1;
      end
      redirect = 1'b0;
   endtask

   task automatic test_redirect_collision();
      do_reset(1'b1, 1);
      for (int c = 1; c <= 10; c++) begin
         redirect  = (c == 6);
         target_pc = 32'h500;
         @(negedge clk);
         if (c == 6) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h10C) begin miscompares++; $display("FAIL coll_head: got v=%b pc=%h want v=1 pc=0000010c", if_valid, if_pc); end
            vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL coll_req_blocked: got %b want 0", imem_req_valid); end
         end
         if (c == 7) begin
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL coll_flushed: got %b pc=%h want 0", if_valid, if_pc); end
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500) begin miscompares++; $display("FAIL coll_req_500: got v=%b a=%h want v=1 a=00000500", imem_req_valid, imem_req_addr); end
         end
         if (c == 8) begin
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL coll_dropped_rsp: got %b pc=%h want 0", if_valid, if_pc); end
         end
         if (c == 9) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h500) begin miscompares++; $display("FAIL coll_target_head: got v=%b pc=%h want v=1 pc=00000500", if_valid, if_pc); end
         end
         if (c == 10) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h504) begin miscompares++; $display("FAIL coll_next_head: got v=%b pc=%h want v=1 pc=00000504", if_valid, if_pc); end
         end
         @(posedge clk); #1;
      end
      redirect = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset(1'b1, 1);
      for (int c = 1; c <= 6; c++) begin
         redirect  = (c == 2);
         target_pc = 32'hFFFF_FFFC;
         @(negedge clk);
         if (c == 3) begin
            vectors++; if (imem_req_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_req_top: got %h want fffffffc", imem_req_addr); end
         end
         if (c == 4) begin
            vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_req_zero: got %h want 00000000", imem_req_addr); end
            vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_stale: got %b pc=%h want 0", if_valid, if_pc); end
         end
         if (c == 5) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_head_top: got v=%b pc=%h want v=1 pc=fffffffc", if_valid, if_pc); end
            vectors++; if (if_pc_plus_4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4_top: got %h want 00000000", if_pc_plus_4); end
         end
         if (c == 6) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== instr_of(32'h0)) begin miscompares++; $display("FAIL wrap_head_zero: got v=%b pc=%h ins=%h want v=1 pc=00000000", if_valid, if_pc, if_instruction); end
            vectors++; if (if_pc_plus_4 !== 32'h4) begin miscompares++; $display("FAIL wrap_pc4_zero: got %h want 00000004", if_pc_plus_4); end
         end
         @(posedge clk); #1;
      end
      redirect = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset(1'b0, 1);
      repeat (6) @(negedge clk);
      vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_filled: got %b want 1", if_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0) begin miscompares++; $display("FAIL midrst_cleared: got v=%b pc=%h ins=%h want v=0 pc=0 ins=0", if_valid, if_pc, if_instruction); end
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
      @(posedge clk); #1;
      rst      = 1'b0;
      if_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL midrst_restart_req: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
         end
         if (c == 3) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin miscompares++; $display("FAIL midrst_restart_head: got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc); end
         end
         if (c == 4) begin
            vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin miscompares++; $display("FAIL midrst_restart_next: got v=%b pc=%h want v=1 pc=00000104", if_valid, if_pc); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect_latency();
      test_double_redirect();
      test_redirect_collision();
      test_wrap();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
